clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
- Mode/sequence controller for the lab digital clock (hour/minute/second counter chains driving BCD-to-7-segment decoders).
- Takes two raw push buttons (MODE, UP) and a 1 Hz tick. Debounces the buttons and runs a set-mode FSM.
- Issues one-cycle increment/clear strobes and a run enable to the counter chains.
- Generates per-field blanking so the field being set blinks on the display.

Parameters:
- DEB_CYCLES, 16, clk_in cycles a synchronized button level must be stable before it is accepted.
- BLINK_DIV, 8, clk_in cycles per blink half-period.
- TIMEOUT_TICKS, 10, 1 Hz ticks with no accepted press before a set state returns to RUN.

Ports:
- clk_in  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- btn_mode  in  1  raw MODE button, asynchronous, active-high.
- btn_up  in  1  raw UP button, asynchronous, active-high.
- tick_1hz  in  1  one-cycle strobe from the frequency divider.
- run_en  out  1  counter chain counts tick_1hz when 1.
- inc_hour  out  1  one-cycle strobe, hour counter +1 (wraps in the counter).
- inc_min  out  1  one-cycle strobe, minute counter +1.
- clr_sec  out  1  one-cycle strobe, seconds counter cleared to 00.
- blank_hour  out  1  1 = blank hour digits this cycle.
- blank_min  out  1  1 = blank minute digits this cycle.
- mode  out  2  current state encoding, for LEDs.

Behaviour:
- Reset: one clock, clk_in. Reset is asynchronous and active-high (rst). While rst is high:
  - FSM goes to RUN; all counters clear; synchronizers clear.
  - run_en=1, mode=0; all strobes and blanks = 0.
- Button path: 2-FF synchronizer, then a stability counter of DEB_CYCLES.
  - The accepted level changes only after DEB_CYCLES consecutive equal synchronized samples.
  - A press pulse (1 cycle) fires on the accepted 0->1 transition.
  - Latency from the raw edge to the press pulse is DEB_CYCLES+2 cycles.
  - Release generates no pulse.
- FSM states and encoding: RUN=0, SET_HOUR=1, SET_MIN=2.
  - RUN + mode press -> SET_HOUR.
  - SET_HOUR + mode press -> SET_MIN.
  - SET_MIN + mode press -> RUN; clr_sec pulses in that same cycle.
  - Any SET state + timeout -> RUN; clr_sec pulses.
- Outputs per state:
  - run_en = 1 only in RUN; the counters freeze in SET states.
  - Up press in SET_HOUR -> inc_hour=1 in the next cycle, for exactly 1 cycle.
  - Up press in SET_MIN -> inc_min=1 in the next cycle, for exactly 1 cycle.
  - Up press in RUN is ignored.
- Simultaneous mode and up press pulses in the same cycle: mode wins; up is discarded.
- Timeout counter:
  - Cleared on entry to any SET state and on every accepted press.
  - Increments on tick_1hz while in a SET state.
  - When the count reaches TIMEOUT_TICKS, the timeout fires and the FSM returns to RUN.
  - If the timeout and a mode press happen in the same cycle, the result is a single transition to RUN with one clr_sec.
- Blink:
  - blink_phase toggles every BLINK_DIV cycles; it is reset to 0 on every state change.
  - blank_hour = (state==SET_HOUR) & blink_phase.
  - blank_min = (state==SET_MIN) & blink_phase.
  - The blink counter free-runs only in SET states and is held at 0 in RUN.
- All outputs are registered. No combinational path from any input to any output.
- rst asserted mid-set: immediate return to RUN; any pending strobe is dropped; no clr_sec is issued.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - UP held (accepted level high) for 4*BLINK_DIV cycles in a SET state starts repeat.
  - Repeat then re-issues the current field's inc strobe every BLINK_DIV cycles until release.
  - Each repeat strobe also clears the timeout counter.
- Undefined: exactly one increment per press; the hold counter logic is absent.

Decomposition:
- Shared package clock_pkg:
  - state encoding constants ST_RUN=2'd0, ST_SET_HOUR=2'd1, ST_SET_MIN=2'd2.
  - Default widths for the debounce and blink counters.
- One sub-module, btn_debounce:
  - Contents: synchronizer, stability counter, press-pulse generator.
  - Parameter: DEB_CYCLES.
  - Instantiated twice (mode, up).

Test Plan (DEB_CYCLES=4, BLINK_DIV=8, TIMEOUT_TICKS=3):
- Reset/idle: rst pulse, then 50 idle cycles -> run_en=1, mode=0; all strobes and blanks 0 throughout.
- Debounce glitch: btn_up toggled every 2 cycles for 20 cycles in SET_HOUR -> zero inc_hour. A clean press of 10 cycles -> exactly one inc_hour, 7 cycles after the raw edge.
- Full sequence: three mode presses with two up presses in SET_HOUR and one in SET_MIN:
  - mode = 1 after the first press, 2 after the second, 0 after the third.
  - inc_hour count 2, inc_min count 1.
  - Exactly one clr_sec, on the SET_MIN->RUN cycle.
  - run_en=0 only between the first and third press.
- Blink: hold in SET_MIN for 64 cycles -> blank_min toggles every 8 cycles starting at 0; blank_hour stays 0.
- Timeout: enter SET_HOUR, then 3 tick_1hz pulses with no press -> return to RUN on the third tick with one clr_sec. An up press between the ticks restarts the count.
- Collision/reset: mode and up presses forced into the same cycle -> state advances with no inc strobe. rst during SET_MIN -> mode=0 asynchronously and no clr_sec.

Source files
------------

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared state encoding and counter widths for the clock set controller
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_t;

  localparam int DEB_CNT_W     = 8;
  localparam int BLINK_CNT_W   = 8;
  localparam int TIMEOUT_CNT_W = 8;
  localparam int HOLD_CNT_W    = 8;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer, stability counter and press-pulse generator
module btn_debounce
  import clock_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk_in,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_CYCLES - 1);

  logic                 sync1;
  logic                 sync2;
  logic [DEB_CNT_W-1:0] cnt;

  // cnt counts consecutive synchronized samples that disagree with the accepted level
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - set-mode FSM, strobes and blink for the digital clock
// Optional hold-to-repeat on UP is built when AUTO_REPEAT_EN is defined.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEB_CYCLES    = 16,
  parameter int BLINK_DIV     = 8,
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       tick_1hz,
  output logic       run_en,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       clr_sec,
  output logic       blank_hour,
  output logic       blank_min,
  output logic [1:0] mode
);

  localparam logic [BLINK_CNT_W-1:0]   BLINK_LAST = BLINK_CNT_W'(BLINK_DIV - 1);
  localparam logic [TIMEOUT_CNT_W-1:0] TO_LAST    = TIMEOUT_CNT_W'(TIMEOUT_TICKS - 1);

  logic mode_level, mode_press, up_level, up_press, up_evt;
  logic in_set, timeout, clr_n, inc_hour_n, inc_min_n, phase, phase_n;
  state_t                   state, state_n;
  logic [BLINK_CNT_W-1:0]   blink_cnt, blink_cnt_n;
  logic [TIMEOUT_CNT_W-1:0] tcnt, tcnt_n;
  logic                     unused_levels;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk_in(clk_in), .rst(rst), .btn(btn_mode), .level(mode_level), .press(mode_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk_in(clk_in), .rst(rst), .btn(btn_up), .level(up_level), .press(up_press)
  );

  assign in_set = (state != ST_RUN);
  assign mode   = state;

`ifdef AUTO_REPEAT_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST  = HOLD_CNT_W'(4 * BLINK_DIV - 1);
  localparam logic [HOLD_CNT_W-1:0] REP_RELOAD = HOLD_CNT_W'(3 * BLINK_DIV);

  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic                  rep_fire;

  // First repeat after 4*BLINK_DIV held cycles; the reload spaces later ones BLINK_DIV apart
  assign rep_fire      = in_set && up_level && (hold_cnt == HOLD_LAST);
  assign up_evt        = up_press | rep_fire;
  assign unused_levels = mode_level;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)                                         hold_cnt <= '0;
    else if (!(in_set && up_level) || state_n != state) hold_cnt <= '0;
    else if (rep_fire)                               hold_cnt <= REP_RELOAD;
    else                                             hold_cnt <= hold_cnt + 1'b1;
  end
`else
  assign up_evt        = up_press;
  assign unused_levels = mode_level ^ up_level;
`endif

  always_comb begin
    state_n     = state;
    clr_n       = 1'b0;
    timeout     = in_set && tick_1hz && (tcnt == TO_LAST);
    // Timeout outranks a coincident mode press so both collapse into one return to RUN
    if (timeout) begin
      state_n = ST_RUN;
      clr_n   = 1'b1;
    end else if (mode_press) begin
      case (state)
        ST_RUN:      state_n = ST_SET_HOUR;
        ST_SET_HOUR: state_n = ST_SET_MIN;
        default: begin
          state_n = ST_RUN;
          clr_n   = 1'b1;
        end
      endcase
    end

    inc_hour_n = up_evt && (state == ST_SET_HOUR) && (state_n == ST_SET_HOUR);
    inc_min_n  = up_evt && (state == ST_SET_MIN) && (state_n == ST_SET_MIN);

    tcnt_n = tcnt;
    if (state_n != state || mode_press || up_evt) tcnt_n = '0;
    else if (in_set && tick_1hz)                  tcnt_n = tcnt + 1'b1;

    blink_cnt_n = blink_cnt + 1'b1;
    phase_n     = phase;
    if (state_n != state || state_n == ST_RUN) begin
      blink_cnt_n = '0;
      phase_n     = 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt_n = '0;
      phase_n     = ~phase;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      tcnt       <= '0;
      blink_cnt  <= '0;
      phase      <= 1'b0;
      run_en     <= 1'b1;
      inc_hour   <= 1'b0;
      inc_min    <= 1'b0;
      clr_sec    <= 1'b0;
      blank_hour <= 1'b0;
      blank_min  <= 1'b0;
    end else begin
      state      <= state_n;
      tcnt       <= tcnt_n;
      blink_cnt  <= blink_cnt_n;
      phase      <= phase_n;
      run_en     <= (state_n == ST_RUN);
      inc_hour   <= inc_hour_n;
      inc_min    <= inc_min_n;
      clr_sec    <= clr_n;
      blank_hour <= (state_n == ST_SET_HOUR) && phase_n;
      blank_min  <= (state_n == ST_SET_MIN) && phase_n;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - directed self-checking bench for clock_set_ctrl
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       run_en, inc_hour, inc_min, clr_sec, blank_hour, blank_min;
  logic [1:0] mode;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  int n_inc_hour = 0, n_inc_min = 0, n_clr = 0, n_run_bad = 0;
  int inc_hour_cyc = -1, clr_cyc = -1, run_entry_cyc = -1;
  int raw_cyc, base_h, base_m, base_c;
  logic [1:0] prev_mode = 2'd0;

  clock_set_ctrl #(.DEB_CYCLES(4), .BLINK_DIV(8), .TIMEOUT_TICKS(3)) dut (
    .clk_in(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up), .tick_1hz(tick_1hz),
    .run_en(run_en), .inc_hour(inc_hour), .inc_min(inc_min), .clr_sec(clr_sec),
    .blank_hour(blank_hour), .blank_min(blank_min), .mode(mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt++;

  always @(negedge clk) begin
    n_inc_hour += int'(inc_hour);
    n_inc_min  += int'(inc_min);
    if (inc_hour) inc_hour_cyc = cyc_cnt;
    if (clr_sec) begin
      n_clr++;
      clr_cyc = cyc_cnt;
    end
    if (mode == 2'd0 && prev_mode != 2'd0) run_entry_cyc = cyc_cnt;
    prev_mode = mode;
    if (run_en !== (mode == 2'd0)) n_run_bad++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    cyc(10);
    btn_mode = 1'b0;
    cyc(10);
  endtask

  task automatic press_up();
    btn_up = 1'b1;
    cyc(10);
    btn_up = 1'b0;
    cyc(10);
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1;
    cyc(1);
    tick_1hz = 1'b0;
    cyc(4);
  endtask

  initial begin
    // Reset and idle
    cyc(3);
    @(negedge clk);
    check("rst_run_en", run_en, 1);
    check("rst_mode", mode, 0);
    check("rst_strobes", {inc_hour, inc_min, clr_sec, blank_hour, blank_min}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_run_en", run_en, 1);
      check("idle_mode", mode, 0);
      check("idle_strobes", {inc_hour, inc_min, clr_sec, blank_hour, blank_min}, 0);
    end
    @(posedge clk);
    #1;

    // Full sequence
    base_h = n_inc_hour;
    base_m = n_inc_min;
    base_c = n_clr;
    press_mode();
    check("seq_mode1", mode, 1);
    check("seq_run_en1", run_en, 0);
    press_up();
    press_up();
    check("seq_mode1b", mode, 1);
    press_mode();
    check("seq_mode2", mode, 2);
    check("seq_run_en2", run_en, 0);
    press_up();
    press_mode();
    check("seq_mode0", mode, 0);
    check("seq_run_en0", run_en, 1);
    check("seq_inc_hour_cnt", n_inc_hour - base_h, 2);
    check("seq_inc_min_cnt", n_inc_min - base_m, 1);
    check("seq_clr_cnt", n_clr - base_c, 1);
    check("seq_clr_cycle", clr_cyc, run_entry_cyc);

    // Debounce glitch then clean press in SET_HOUR
    press_mode();
    check("deb_mode", mode, 1);
    base_h = n_inc_hour;
    for (int i = 0; i < 10; i++) begin
      btn_up = (i % 2 == 0);
      cyc(2);
    end
    btn_up = 1'b0;
    cyc(10);
    check("deb_glitch_inc", n_inc_hour - base_h, 0);
    raw_cyc = cyc_cnt;
    btn_up = 1'b1;
    cyc(10);
    btn_up = 1'b0;
    cyc(10);
    check("deb_clean_inc", n_inc_hour - base_h, 1);
    check("deb_latency", inc_hour_cyc - raw_cyc, 7);

    // Blink in SET_MIN
    btn_mode = 1'b1;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (mode == 2'd2) break;
    end
    check("blink_enter", mode, 2);
    for (int i = 0; i < 64; i++) begin
      check("blink_min", blank_min, (i >> 3) & 1);
      check("blink_hour", blank_hour, 0);
      if (i == 4) btn_mode = 1'b0;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    press_mode();
    check("blink_exit", mode, 0);

    // Timeout, with an up press restarting the count
    press_mode();
    check("to_enter", mode, 1);
    pulse_tick();
    pulse_tick();
    check("to_two_ticks", mode, 1);
    press_up();
    pulse_tick();
    pulse_tick();
    check("to_restart", mode, 1);
    base_c = n_clr;
    tick_1hz = 1'b1;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0;
    @(negedge clk);
    check("to_mode", mode, 0);
    check("to_clr", clr_sec, 1);
    cyc(5);
    check("to_clr_cnt", n_clr - base_c, 1);

    // Collision: mode and up presses in the same cycle
    press_mode();
    check("col_enter", mode, 1);
    base_h = n_inc_hour;
    base_m = n_inc_min;
    btn_mode = 1'b1;
    btn_up = 1'b1;
    cyc(10);
    btn_mode = 1'b0;
    btn_up = 1'b0;
    cyc(10);
    check("col_mode", mode, 2);
    check("col_inc", (n_inc_hour - base_h) + (n_inc_min - base_m), 0);

    // Reset during SET_MIN
    base_c = n_clr;
    rst = 1'b1;
    #1;
    check("rst_async_mode", mode, 0);
    check("rst_async_run_en", run_en, 1);
    cyc(3);
    rst = 1'b0;
    cyc(10);
    check("rst_no_clr", n_clr - base_c, 0);
    check("rst_final_mode", mode, 0);
    check("run_en_tracks_mode", n_run_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
